// File: rtl/mem2_stage_pkg.sv
// Shared types for the MEM2 pipeline stage: load-type fields, write-back select
// encodings and the response-tracking FSM states.
package mem2_stage_pkg;

  typedef struct packed {
    logic       rd;
    logic       sgn;
    logic [1:0] size;
  } load_type_t;

  localparam logic [1:0] WB_PC8  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_OUTB = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} mem2_state_t;

endpackage

// File: rtl/mem2_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half of the response
// word and sign- or zero-extends it; word loads pass through.
module load_align
  import mem2_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic        i_sgn,
  input  logic [1:0]  i_size,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    case (i_size)
      SZ_B:    o_data = {{24{i_sgn & w_byte[7]}}, w_byte};
      SZ_H:    o_data = {{16{i_sgn & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem2_stage.sv
// Second memory stage: latches MEM results, tracks the outstanding DCache load
// response, aligns load data and selects the write-back / bypass value.
module mem2_stage
  import mem2_stage_pkg::*;
#(
  parameter int RESP_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        MEM2_Flush,
  input  logic        MEM2_Wr,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  logic [4:0]  MEM_Dst,
  input  logic        MEM_RFWr,
  input  logic [1:0]  MEM_WbSel,
  input  logic [3:0]  MEM_LoadType,
  input  logic        MEM_IsABranch,
  input  logic        MEM_DReqIssued,
  input  logic        dcache_rvalid,
  input  logic [31:0] dcache_rdata,
  output logic [31:0] MEM2_PC,
  output logic [4:0]  MEM2_Dst,
  output logic        MEM2_RFWr,
  output logic [31:0] MEM2_Result,
  output logic        MEM2_ResultValid,
  output logic        MEM2_IsABranch,
  output logic        MEM2_StallReq,
  output logic        dbg_timeout
);

  localparam logic [31:0] RT = 32'(RESP_TIMEOUT);

  logic        r_vld, r_rfwr, r_br;
  logic [31:0] r_pc, r_alu, r_outb, r_hold, r_cnt;
  logic [4:0]  r_dst;
  logic [1:0]  r_wbsel;
  load_type_t  r_lt;
  logic        r_timeout;
  mem2_state_t r_state, w_state_nxt;

  logic        w_new_req, w_waiting;
  logic [31:0] w_ld_src, w_ld_data, w_result;

  assign w_new_req = MEM2_Wr & ~MEM2_Flush & MEM_DReqIssued;
  assign w_waiting = (r_state == WAIT) || (r_state == DRAIN);

  always_ff @(posedge clk) begin
    if (!resetn || MEM2_Flush) begin
      r_vld   <= 1'b0;
      r_pc    <= '0;
      r_alu   <= '0;
      r_outb  <= '0;
      r_dst   <= '0;
      r_rfwr  <= 1'b0;
      r_wbsel <= '0;
      r_lt    <= '0;
      r_br    <= 1'b0;
    end else if (MEM2_Wr) begin
      r_vld   <= 1'b1;
      r_pc    <= MEM_PC;
      r_alu   <= MEM_ALUOut;
      r_outb  <= MEM_OutB;
      r_dst   <= MEM_Dst;
      r_rfwr  <= MEM_RFWr;
      r_wbsel <= MEM_WbSel;
      r_lt    <= load_type_t'(MEM_LoadType);
      r_br    <= MEM_IsABranch;
    end
  end

  // A load entering on the same edge its predecessor completes goes straight
  // back to WAIT so back-to-back loads never pass through IDLE unprotected.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_new_req && !dcache_rvalid) w_state_nxt = WAIT;
      WAIT: begin
        if (dcache_rvalid) begin
          if (MEM2_Flush)   w_state_nxt = IDLE;
          else if (MEM2_Wr) w_state_nxt = w_new_req ? WAIT : IDLE;
          else              w_state_nxt = HOLD;
        end else if (MEM2_Flush) begin
          w_state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (MEM2_Flush)   w_state_nxt = IDLE;
        else if (MEM2_Wr) w_state_nxt = w_new_req ? WAIT : IDLE;
      end
      DRAIN: if (dcache_rvalid) w_state_nxt = w_new_req ? WAIT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= 1'b0;
      if (r_state == WAIT && dcache_rvalid && !MEM2_Flush && !MEM2_Wr)
        r_hold <= dcache_rdata;
      // Counter saturates at RT so the debug pulse fires only once per wait.
      if (w_waiting && !dcache_rvalid && w_state_nxt == r_state) begin
        if (r_cnt != RT) r_cnt <= r_cnt + 32'd1;
        r_timeout <= (RT != 32'd0) && (r_cnt == RT - 32'd1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_ld_src = (r_state == HOLD) ? r_hold : dcache_rdata;

  load_align u_align (
    .i_rdata (w_ld_src),
    .i_off   (r_alu[1:0]),
    .i_sgn   (r_lt.sgn),
    .i_size  (r_lt.size),
    .o_data  (w_ld_data)
  );

  always_comb begin
    w_result = '0;
    if (r_vld) begin
      case (r_wbsel)
        WB_PC8:  w_result = r_pc + 32'd8;
        WB_ALU:  w_result = r_alu;
        WB_OUTB: w_result = r_outb;
        default: w_result = w_ld_data;
      endcase
    end
  end

  assign MEM2_PC          = r_pc;
  assign MEM2_Dst         = r_dst;
  assign MEM2_RFWr        = r_rfwr;
  assign MEM2_IsABranch   = r_br;
  assign MEM2_Result      = w_result;
  assign MEM2_ResultValid = r_vld & ~(r_lt.rd & w_waiting);
  assign MEM2_StallReq    = ~dcache_rvalid &
                            ((r_state == WAIT) || ((r_state == DRAIN) && MEM_DReqIssued));
  assign dbg_timeout      = r_timeout;

endmodule

// File: tb/tb_mem2_stage.sv
// Self-checking bench for mem2_stage: directed scenarios plus randomized loads
// checked against an arithmetic model of load alignment and result selection.
module tb_mem2_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        MEM2_Flush = 1'b0, MEM2_Wr = 1'b0;
  logic [31:0] MEM_PC = '0, MEM_ALUOut = '0, MEM_OutB = '0;
  logic [4:0]  MEM_Dst = '0;
  logic        MEM_RFWr = 1'b0;
  logic [1:0]  MEM_WbSel = '0;
  logic [3:0]  MEM_LoadType = '0;
  logic        MEM_IsABranch = 1'b0, MEM_DReqIssued = 1'b0;
  logic        dcache_rvalid = 1'b0;
  logic [31:0] dcache_rdata = '0;
  logic [31:0] MEM2_PC, MEM2_Result;
  logic [4:0]  MEM2_Dst;
  logic        MEM2_RFWr, MEM2_ResultValid, MEM2_IsABranch, MEM2_StallReq, dbg_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem2_stage #(.RESP_TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .MEM2_Flush(MEM2_Flush), .MEM2_Wr(MEM2_Wr),
    .MEM_PC(MEM_PC), .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB), .MEM_Dst(MEM_Dst),
    .MEM_RFWr(MEM_RFWr), .MEM_WbSel(MEM_WbSel), .MEM_LoadType(MEM_LoadType),
    .MEM_IsABranch(MEM_IsABranch), .MEM_DReqIssued(MEM_DReqIssued),
    .dcache_rvalid(dcache_rvalid), .dcache_rdata(dcache_rdata),
    .MEM2_PC(MEM2_PC), .MEM2_Dst(MEM2_Dst), .MEM2_RFWr(MEM2_RFWr),
    .MEM2_Result(MEM2_Result), .MEM2_ResultValid(MEM2_ResultValid),
    .MEM2_IsABranch(MEM2_IsABranch), .MEM2_StallReq(MEM2_StallReq),
    .dbg_timeout(dbg_timeout)
  );

  // Load value model: pick the addressed lane by division, then extend arithmetically.
  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] off,
                                             input logic sgn, input logic [1:0] size);
    longint unsigned v, span;
    if (size == 2'd0) begin
      span = 256;
      v = (64'(d) / (64'd1 << (8 * off))) % span;
    end else if (size == 2'd1) begin
      span = 65536;
      v = (64'(d) / (64'd1 << (16 * off[1]))) % span;
    end else begin
      return d;
    end
    if (sgn && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_pc8(input logic [31:0] pc);
    longint unsigned s;
    s = (64'(pc) + 64'd8) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] outb,
                        input logic [1:0] wbsel, input logic [3:0] lt, input logic req);
    MEM_PC = pc; MEM_ALUOut = alu; MEM_OutB = outb; MEM_WbSel = wbsel;
    MEM_LoadType = lt; MEM_DReqIssued = req; MEM_Dst = 5'($urandom);
    MEM_RFWr = 1'b1; MEM_IsABranch = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; MEM2_Wr = 1'b1;
    set_op($urandom, $urandom, $urandom, 2'b01, 4'b0, 1'b0);
    tick(); tick();
    checks++;
    if ({MEM2_PC, MEM2_Dst, MEM2_RFWr, MEM2_Result, MEM2_ResultValid, MEM2_IsABranch,
         MEM2_StallReq, dbg_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pc=%h res=%h rv=%b stall=%b exp all zero",
               MEM2_PC, MEM2_Result, MEM2_ResultValid, MEM2_StallReq);
    end
    resetn = 1'b1; MEM2_Wr = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] exp;
    logic [4:0]  dst;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_op($urandom, 32'h1234_5678, $urandom, 2'b01, 4'b0, 1'b0);
      else set_op($urandom, $urandom, $urandom, (i % 2 == 1) ? 2'b10 : 2'b01, 4'b0, 1'b0);
      exp = (MEM_WbSel == 2'b10) ? MEM_OutB : MEM_ALUOut;
      dst = MEM_Dst;
      MEM2_Wr = 1'b1;
      tick();
      checks++;
      if (MEM2_Result !== exp || MEM2_ResultValid !== 1'b1 || MEM2_StallReq !== 1'b0) begin
        errors++;
        $display("FAIL alu_result got=%h rv=%b stall=%b exp=%h rv=1 stall=0",
                 MEM2_Result, MEM2_ResultValid, MEM2_StallReq, exp);
      end
      checks++;
      if (MEM2_Dst !== dst || MEM2_RFWr !== 1'b1) begin
        errors++;
        $display("FAIL alu_dst got=%0d/%b exp=%0d/1", MEM2_Dst, MEM2_RFWr, dst);
      end
    end
  endtask

  task automatic test_jal();
    logic [31:0] pcs [5];
    pcs[0] = 32'hBFC0_0100; pcs[1] = 32'hFFFF_FFFC; pcs[2] = 32'hFFFF_FFF8;
    pcs[3] = $urandom; pcs[4] = $urandom;
    for (int i = 0; i < 5; i++) begin
      set_op(pcs[i], $urandom, $urandom, 2'b00, 4'b0, 1'b0);
      MEM_IsABranch = 1'b1; MEM2_Wr = 1'b1;
      tick();
      checks++;
      if (MEM2_Result !== model_pc8(pcs[i]) || MEM2_IsABranch !== 1'b1 || MEM2_PC !== pcs[i]) begin
        errors++;
        $display("FAIL jal_pc8 pc=%h got=%h br=%b exp=%h br=1",
                 pcs[i], MEM2_Result, MEM2_IsABranch, model_pc8(pcs[i]));
      end
    end
    checks++;
    if (model_pc8(32'hFFFF_FFFC) !== 32'h0000_0004 || pcs[0] + 32'd8 !== 32'hBFC0_0108) begin
      errors++;
      $display("FAIL jal_model got=%h exp=00000004", model_pc8(32'hFFFF_FFFC));
    end
  endtask

  task automatic run_load(input logic [31:0] alu, input logic [3:0] lt, input logic [31:0] rdata,
                          input int lat, input bit hold, input logic [31:0] exp);
    logic [31:0] next_alu;
    set_op($urandom, alu, $urandom, 2'b11, lt, 1'b1);
    MEM2_Wr = 1'b1; dcache_rvalid = 1'b0;
    tick();
    set_op($urandom, $urandom, $urandom, 2'b01, 4'b0, 1'b0);
    next_alu = MEM_ALUOut;
    MEM2_Wr = 1'b0;
    for (int i = 0; i < lat; i++) begin
      #1;
      checks++;
      if (MEM2_StallReq !== 1'b1 || MEM2_ResultValid !== 1'b0) begin
        errors++;
        $display("FAIL load_wait cyc=%0d got stall=%b rv=%b exp stall=1 rv=0",
                 i, MEM2_StallReq, MEM2_ResultValid);
      end
      tick();
    end
    dcache_rvalid = 1'b1; dcache_rdata = rdata; MEM2_Wr = !hold;
    #1;
    checks++;
    if (MEM2_StallReq !== 1'b0 || (!hold && MEM2_Result !== exp)) begin
      errors++;
      $display("FAIL load_live got=%h stall=%b exp=%h stall=0", MEM2_Result, MEM2_StallReq, exp);
    end
    tick();
    dcache_rvalid = 1'b0; dcache_rdata = $urandom;
    if (hold) begin
      #1;
      checks++;
      if (MEM2_Result !== exp || MEM2_ResultValid !== 1'b1 || MEM2_StallReq !== 1'b0) begin
        errors++;
        $display("FAIL load_hold got=%h rv=%b stall=%b exp=%h rv=1 stall=0",
                 MEM2_Result, MEM2_ResultValid, MEM2_StallReq, exp);
      end
      MEM2_Wr = 1'b1;
      tick();
    end
    #1;
    checks++;
    if (MEM2_Result !== next_alu || MEM2_ResultValid !== 1'b1 || MEM2_StallReq !== 1'b0) begin
      errors++;
      $display("FAIL after_load got=%h rv=%b stall=%b exp=%h rv=1 stall=0",
               MEM2_Result, MEM2_ResultValid, MEM2_StallReq, next_alu);
    end
  endtask

  task automatic test_lb();
    run_load(32'h1000_0003, 4'b1100, 32'h80AA_BBCC, 2, 1'b0, 32'hFFFF_FF80);
  endtask

  task automatic test_lhu_hold();
    run_load(32'h1000_0002, 4'b1001, 32'h9ABC_0000, 1, 1'b1, 32'h0000_9ABC);
  endtask

  task automatic test_random_loads();
    logic [1:0]  size, off;
    logic        sgn;
    logic [31:0] d;
    for (int i = 0; i < 30; i++) begin
      size = 2'($urandom_range(0, 2));
      sgn  = 1'($urandom);
      off  = (size == 2'd0) ? 2'($urandom) : (size == 2'd1) ? {1'($urandom), 1'b0} : 2'b00;
      d    = $urandom;
      run_load({$urandom_range(0, 32'h3FFF_FFFF) * 4} [31:0] | 32'(off), {1'b1, sgn, size}, d,
               $urandom_range(0, 3), 1'($urandom), model_load(d, off, sgn, size));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] da, db, next_alu;
    da = $urandom; db = $urandom;
    set_op($urandom, 32'h0000_0040, $urandom, 2'b11, 4'b1010, 1'b1);
    MEM2_Wr = 1'b1;
    tick();
    set_op($urandom, 32'h0000_0041, $urandom, 2'b11, 4'b1000, 1'b1);
    dcache_rvalid = 1'b1; dcache_rdata = da;
    #1;
    checks++;
    if (MEM2_Result !== da || MEM2_StallReq !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got=%h stall=%b exp=%h stall=0", MEM2_Result, MEM2_StallReq, da);
    end
    tick();
    dcache_rvalid = 1'b0; MEM_DReqIssued = 1'b0; MEM2_Wr = 1'b0;
    #1;
    checks++;
    if (MEM2_StallReq !== 1'b1 || MEM2_ResultValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_wait got stall=%b rv=%b exp stall=1 rv=0",
               MEM2_StallReq, MEM2_ResultValid);
    end
    tick();
    set_op($urandom, $urandom, $urandom, 2'b01, 4'b0, 1'b0);
    next_alu = MEM_ALUOut;
    dcache_rvalid = 1'b1; dcache_rdata = db; MEM2_Wr = 1'b1;
    #1;
    checks++;
    if (MEM2_Result !== model_load(db, 2'd1, 1'b0, 2'd0) || MEM2_StallReq !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got=%h exp=%h", MEM2_Result, model_load(db, 2'd1, 1'b0, 2'd0));
    end
    tick();
    dcache_rvalid = 1'b0;
    checks++;
    if (MEM2_Result !== next_alu) begin
      errors++;
      $display("FAIL b2b_after got=%h exp=%h", MEM2_Result, next_alu);
    end
  endtask

  task automatic test_flush_drain();
    logic [31:0] next_alu;
    set_op($urandom, 32'h0000_2000, $urandom, 2'b11, 4'b1010, 1'b1);
    MEM2_Wr = 1'b1;
    tick();
    MEM2_Wr = 1'b0; MEM_DReqIssued = 1'b0; MEM2_Flush = 1'b1;
    tick();
    MEM2_Flush = 1'b0;
    #1;
    checks++;
    if (MEM2_StallReq !== 1'b0 || MEM2_ResultValid !== 1'b0) begin
      errors++;
      $display("FAIL drain_noreq got stall=%b rv=%b exp stall=0 rv=0", MEM2_StallReq, MEM2_ResultValid);
    end
    set_op($urandom, 32'h0000_3000, $urandom, 2'b11, 4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (MEM2_StallReq !== 1'b1 || MEM2_Result !== 32'h0 || MEM2_ResultValid !== 1'b0) begin
        errors++;
        $display("FAIL drain_stall cyc=%0d got stall=%b res=%h exp stall=1 res=0",
                 i, MEM2_StallReq, MEM2_Result);
      end
      tick();
    end
    dcache_rvalid = 1'b1; dcache_rdata = 32'hDEAD_BEEF; MEM2_Wr = 1'b1;
    #1;
    checks++;
    if (MEM2_StallReq !== 1'b0 || MEM2_Result === 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL drain_orphan got stall=%b res=%h exp stall=0 res!=deadbeef",
               MEM2_StallReq, MEM2_Result);
    end
    tick();
    dcache_rvalid = 1'b0; dcache_rdata = 32'h0; MEM2_Wr = 1'b0; MEM_DReqIssued = 1'b0;
    #1;
    checks++;
    if (MEM2_StallReq !== 1'b1 || MEM2_ResultValid !== 1'b0 || MEM2_Result === 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL drain_newload got stall=%b rv=%b res=%h exp stall=1 rv=0",
               MEM2_StallReq, MEM2_ResultValid, MEM2_Result);
    end
    tick();
    set_op($urandom, $urandom, $urandom, 2'b01, 4'b0, 1'b0);
    next_alu = MEM_ALUOut;
    dcache_rvalid = 1'b1; dcache_rdata = 32'h1122_3344; MEM2_Wr = 1'b1;
    #1;
    checks++;
    if (MEM2_Result !== 32'h1122_3344 || MEM2_StallReq !== 1'b0) begin
      errors++;
      $display("FAIL drain_realdata got=%h exp=11223344", MEM2_Result);
    end
    tick();
    dcache_rvalid = 1'b0;
    checks++;
    if (MEM2_Result !== next_alu || MEM2_ResultValid !== 1'b1) begin
      errors++;
      $display("FAIL drain_after got=%h exp=%h", MEM2_Result, next_alu);
    end
  endtask

  task automatic test_flush_hold();
    set_op($urandom, 32'h0000_5000, $urandom, 2'b11, 4'b1010, 1'b1);
    MEM2_Wr = 1'b1;
    tick();
    MEM2_Wr = 1'b0; MEM_DReqIssued = 1'b0; dcache_rvalid = 1'b1; dcache_rdata = $urandom;
    tick();
    dcache_rvalid = 1'b0; MEM2_Flush = 1'b1;
    tick();
    MEM2_Flush = 1'b0;
    checks++;
    if (MEM2_Result !== 32'h0 || MEM2_ResultValid !== 1'b0 || MEM2_StallReq !== 1'b0 ||
        MEM2_RFWr !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold got res=%h rv=%b stall=%b rfwr=%b exp all 0",
               MEM2_Result, MEM2_ResultValid, MEM2_StallReq, MEM2_RFWr);
    end
  endtask

  task automatic test_reset_in_wait();
    set_op($urandom, 32'h0000_6000, $urandom, 2'b11, 4'b1010, 1'b1);
    MEM2_Wr = 1'b1;
    tick();
    MEM2_Wr = 1'b0; MEM_DReqIssued = 1'b0;
    checks++;
    if (MEM2_StallReq !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_pre got stall=%b exp=1", MEM2_StallReq);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if ({MEM2_PC, MEM2_Dst, MEM2_RFWr, MEM2_Result, MEM2_ResultValid, MEM2_IsABranch,
         MEM2_StallReq, dbg_timeout} !== '0) begin
      errors++;
      $display("FAIL rst_wait got res=%h stall=%b pc=%h exp all zero",
               MEM2_Result, MEM2_StallReq, MEM2_PC);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (MEM2_StallReq !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_post got stall=%b exp=0", MEM2_StallReq);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    set_op($urandom, 32'h0000_7000, $urandom, 2'b11, 4'b1010, 1'b1);
    MEM2_Wr = 1'b1;
    tick();
    MEM2_Wr = 1'b0; MEM_DReqIssued = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++;
      if (dbg_timeout !== (k == 8) || MEM2_StallReq !== 1'b1) begin
        errors++;
        $display("FAIL timeout cyc=%0d got dbg=%b stall=%b exp dbg=%b stall=1",
                 k, dbg_timeout, MEM2_StallReq, (k == 8));
      end
      if (dbg_timeout === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL timeout_pulses got=%0d exp=1", pulses);
    end
    set_op($urandom, $urandom, $urandom, 2'b01, 4'b0, 1'b0);
    dcache_rvalid = 1'b1; MEM2_Wr = 1'b1;
    tick();
    dcache_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jal();
    test_lb();
    test_lhu_hold();
    test_random_loads();
    test_back_to_back();
    test_flush_drain();
    test_flush_hold();
    test_reset_in_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
